execute_md: RTL and testbench

EXECUTE_MD -- requirements
Module: execute_md

---
 rtl/execute_md.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_execute_md.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// ---------------------------------------------------------------------------
// execute_md -- iterative multiply / divide unit for the execute stage.
//
// Multiplies with a shift-add datapath and divides with a restoring divider.
// Each retires ITER_BITS bits per cycle. Signed operands become magnitudes at
// launch. The result sign is applied to the final value, and that value is
// loaded into result_E on the edge that enters DONE.
//
// Optional feature: define EXECUTE_MD_DIV_EN to build the divider (ops 4-7).
// Without it, ops 4-7 finish in one cycle with result 0 and illegal_E=1.
//
// Parameters:
//   N          datapath width (even, >= 32)
//   ITER_BITS  bits retired per iteration cycle (1 or 2)
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start_E      launch request, sampled in IDLE only
//   flush_E      abort the in-flight operation (wins over start_E)
//   MdOp         0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   w_arith      32-bit operation; the result is sign-extended from bit 31
//   readData1_E  operand a
//   readData2_E  operand b
//   result_E     registered result, held until the next accepted start
//   busy_E       operation in flight (from the cycle after launch through DONE)
//   done_E       one-cycle result-valid pulse
//   stall_E      hold the upstream pipeline
//   illegal_E    pulses with done_E for a compiled-out op
// ---------------------------------------------------------------------------
module execute_md #(
  parameter int N         = 64,
  parameter int ITER_BITS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_E,
  input  logic         flush_E,
  input  logic [2:0]   MdOp,
  input  logic         w_arith,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic [N-1:0] result_E,
  output logic         busy_E,
  output logic         done_E,
  output logic         stall_E,
  output logic         illegal_E
);

  localparam int CW = $clog2(N / ITER_BITS + 1);
  // The counter holds (iterations - 1). Its last value is 0.
  localparam logic [CW-1:0] CNT_N = CW'(N / ITER_BITS - 1);
  localparam logic [CW-1:0] CNT_W = CW'(32 / ITER_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef EXECUTE_MD_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;          // MdOp[1:0]; the state already encodes MdOp[2]
  logic            w_q, w_d;
  logic            neg_q, neg_d;        // negate the magnitude result at the end
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic [N-1:0]    result_q, result_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;

  genvar gi;

  // Replace bits above 31 with bit 31 for W-form results.
  function automatic logic [N-1:0] fix_w(input logic [N-1:0] x, input logic w);
    logic [N-1:0] y;
    y = x;
    if (w) begin
      for (int i = 32; i < N; i++) y[i] = x[31];
    end
    return y;
  endfunction

  // ---------------- launch decode ----------------
  logic         launch, last_iter;
  logic [N-1:0] op_mask, a_ext, b_ext, mag_a, mag_b;
  logic         a_msb, b_msb, a_sgn, b_sgn, sa, sb, b_zero, neg_l;

  assign launch    = (state_q == S_IDLE) & start_E & ~flush_E;
  assign last_iter = (cnt_q == '0);

  always_comb begin
    op_mask = w_arith ? N'(32'hFFFF_FFFF) : {N{1'b1}};
    a_ext   = readData1_E & op_mask;
    b_ext   = readData2_E & op_mask;
    a_msb   = w_arith ? readData1_E[31] : readData1_E[N-1];
    b_msb   = w_arith ? readData2_E[31] : readData2_E[N-1];
    a_sgn   = (MdOp == 3'd1) | (MdOp == 3'd2) | (MdOp == 3'd4) | (MdOp == 3'd6);
    b_sgn   = (MdOp == 3'd1) | (MdOp == 3'd4) | (MdOp == 3'd6);
    sa      = a_sgn & a_msb;
    sb      = b_sgn & b_msb;
    mag_a   = sa ? ((-a_ext) & op_mask) : a_ext;
    mag_b   = sb ? ((-b_ext) & op_mask) : b_ext;
    b_zero  = (b_ext == '0);
    case (MdOp)
      // Divide by zero must keep the all-ones quotient, so it is never negated.
      3'd4, 3'd5: neg_l = (sa ^ sb) & ~b_zero;
      3'd6, 3'd7: neg_l = sa;           // remainder follows the dividend sign
      default:    neg_l = sa ^ sb;
    endcase
  end

  // ---------------- multiplier step ----------------
  logic [ITER_BITS:0][2*N-1:0] mul_sum;
  assign mul_sum[0] = acc_q;
  generate
    for (gi = 0; gi < ITER_BITS; gi++) begin : g_mul_step
      assign mul_sum[gi+1] = mul_sum[gi] + ((mcand_q << gi) & {(2*N){mplier_q[gi]}});
    end
  endgenerate

  logic [2*N-1:0] prod_s;
  logic [N-1:0]   mul_raw, mul_res;
  always_comb begin
    prod_s  = neg_q ? -mul_sum[ITER_BITS] : mul_sum[ITER_BITS];
    mul_raw = (op_q == 2'd0) ? prod_s[N-1:0]
                             : (w_q ? N'(prod_s[63:32]) : prod_s[2*N-1:N]);
    mul_res = fix_w(mul_raw, w_q);
  end

`ifdef EXECUTE_MD_DIV_EN
  // ---------------- restoring divider step ----------------
  // The dividend is left-aligned in quo_q so that W-form and full-width
  // divides both shift from the MSB. Quotient bits enter at the LSB.
  logic [N-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [ITER_BITS:0][N-1:0] div_rem, div_quo;
  assign div_rem[0] = rem_q;
  assign div_quo[0] = quo_q;
  generate
    for (gi = 0; gi < ITER_BITS; gi++) begin : g_div_step
      logic [N-1:0] sh;
      logic [N:0]   diff;
      logic         ge;
      assign sh   = {div_rem[gi][N-2:0], div_quo[gi][N-1]};
      assign diff = {1'b0, sh} - {1'b0, dvsr_q};
      // The bit shifted out of the partial remainder counts as 2^N.
      assign ge   = div_rem[gi][N-1] | ~diff[N];
      assign div_rem[gi+1] = ge ? diff[N-1:0] : sh;
      assign div_quo[gi+1] = {div_quo[gi][N-2:0], ge};
    end
  endgenerate

  logic [N-1:0] div_raw, div_res;
  always_comb begin
    div_raw = op_q[1] ? div_rem[ITER_BITS] : div_quo[ITER_BITS];
    div_res = fix_w(neg_q ? -div_raw : div_raw, w_q);
  end
`endif

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          if (MdOp[2]) begin
`ifdef EXECUTE_MD_DIV_EN
            state_d = S_DIV;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush_E)        state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
`ifdef EXECUTE_MD_DIV_EN
      S_DIV: begin
        if (flush_E)        state_d = S_IDLE;
        else if (last_iter) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    op_d      = op_q;
    w_d       = w_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    result_d  = result_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`ifdef EXECUTE_MD_DIV_EN
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
`endif
    if (launch) begin
      op_d      = MdOp[1:0];
      w_d       = w_arith;
      neg_d     = neg_l;
      cnt_d     = w_arith ? CNT_W : CNT_N;
      illegal_d = 1'b0;
      acc_d     = '0;
      mcand_d   = {{N{1'b0}}, mag_a};
      mplier_d  = mag_b;
`ifdef EXECUTE_MD_DIV_EN
      rem_d     = '0;
      quo_d     = w_arith ? (mag_a << (N - 32)) : mag_a;
      dvsr_d    = mag_b;
`else
      if (MdOp[2]) begin
        illegal_d = 1'b1;
        result_d  = '0;
      end
`endif
    end
    if (state_q == S_MUL) begin
      acc_d    = mul_sum[ITER_BITS];
      mcand_d  = mcand_q << ITER_BITS;
      mplier_d = mplier_q >> ITER_BITS;
      cnt_d    = cnt_q - CW'(1);
      if (last_iter && !flush_E) result_d = mul_res;
    end
`ifdef EXECUTE_MD_DIV_EN
    if (state_q == S_DIV) begin
      rem_d = div_rem[ITER_BITS];
      quo_d = div_quo[ITER_BITS];
      cnt_d = cnt_q - CW'(1);
      if (last_iter && !flush_E) result_d = div_res;
    end
`endif
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      w_q       <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
`ifdef EXECUTE_MD_DIV_EN
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      w_q       <= w_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`ifdef EXECUTE_MD_DIV_EN
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
`endif
    end
  end

  // ---------------- outputs ----------------
  assign result_E  = result_q;
  assign busy_E    = (state_q != S_IDLE);
  assign done_E    = (state_q == S_DONE);
  assign illegal_E = illegal_q & done_E;
  assign stall_E   = (start_E & (state_q == S_IDLE)) | (busy_E & ~done_E);

endmodule

// File: tb/tb_execute_md.sv
// ---------------------------------------------------------------------------
// tb_execute_md -- scoreboard bench for execute_md (N=64, ITER_BITS=1).
// The stimulus pushes the expected result, illegal flag and latency of each
// launch into a queue. A monitor pops and compares on every done_E.
// Expected values for the random traffic come from an arithmetic model.
// ---------------------------------------------------------------------------
module tb_execute_md;
  localparam int N = 64;
`ifdef EXECUTE_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_E = 1'b0;
  logic         flush_E = 1'b0;
  logic [2:0]   MdOp = 3'd0;
  logic         w_arith = 1'b0;
  logic [N-1:0] readData1_E = '0;
  logic [N-1:0] readData2_E = '0;
  logic [N-1:0] result_E;
  logic         busy_E, done_E, stall_E, illegal_E;

  execute_md #(.N(N), .ITER_BITS(1)) dut (
    .clk(clk), .reset(reset), .start_E(start_E), .flush_E(flush_E),
    .MdOp(MdOp), .w_arith(w_arith), .readData1_E(readData1_E),
    .readData2_E(readData2_E), .result_E(result_E), .busy_E(busy_E),
    .done_E(done_E), .stall_E(stall_E), .illegal_E(illegal_E)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [63:0] last_res = '0;

  typedef struct {
    logic [63:0] res;
    logic        ill;
    int          t0;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model written from the arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] as, bs, au, bu, p;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] r;
    if (w) begin
      as = {{96{a[31]}}, a[31:0]}; bs = {{96{b[31]}}, b[31:0]};
      au = {96'b0, a[31:0]};       bu = {96'b0, b[31:0]};
    end else begin
      as = {{64{a[63]}}, a}; bs = {{64{b[63]}}, b};
      au = {64'b0, a};       bu = {64'b0, b};
    end
    sa = as[63:0]; sb = bs[63:0]; ua = au[63:0]; ub = bu[63:0];
    p = '0;
    r = '0;
    case (op)
      3'd0: begin p = au * bu; r = p[63:0]; end
      3'd1: begin p = as * bs; r = w ? {32'b0, p[63:32]} : p[127:64]; end
      3'd2: begin p = as * bu; r = w ? {32'b0, p[63:32]} : p[127:64]; end
      3'd3: begin p = au * bu; r = w ? {32'b0, p[63:32]} : p[127:64]; end
      3'd4: begin
        if (ub == 0)       r = '1;
        else if (sb == -1) r = 0 - sa;
        else               r = sa / sb;
      end
      3'd5: r = (ub == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ua / ub;
      3'd6: begin
        if (ub == 0)       r = sa;
        else if (sb == -1) r = '0;
        else               r = sa % sb;
      end
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic logic [63:0] dv(input logic [63:0] v);
    return DIV_EN ? v : 64'd0;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (reset && done_E) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: actual=done_E 1 required=no pending op (cycle %0d)", cyc);
      end else begin
        automatic exp_t e = sb_q.pop_front();
        chk("result", result_E, e.res);
        chk("illegal", 64'(illegal_E), 64'(e.ill));
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("busy_at_done", 64'(busy_E), 64'd1);
        chk("stall_at_done", 64'(stall_E), 64'd0);
        $display("[TB] done result=%h illegal=%0b latency=%0d", result_E, illegal_E, cyc - e.t0);
      end
    end
  end

  // Runs the in-flight op to idle, with random start/operand noise while busy.
  task automatic finish_op(input int lat, input string tag);
    bit idle_seen;
    idle_seen = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_busy_c1"}, 64'(busy_E), 64'd1);
        chk({tag, "_stall_c1"}, 64'(stall_E), 64'(lat != 1));
        start_E = 1'b0;
      end
      if (done_E) begin
        start_E = 1'b0;
      end else if (!busy_E) begin
        idle_seen = 1'b1;
        break;
      end else if (k > 1) begin
        start_E     = 1'($urandom_range(0, 1));
        MdOp        = 3'($urandom);
        w_arith     = 1'($urandom);
        readData1_E = {$urandom, $urandom};
        readData2_E = {$urandom, $urandom};
      end
    end
    start_E = 1'b0;
    if (!idle_seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: actual=still busy required=idle within 200 cycles", tag);
    end
  endtask

  // Called at a negedge while the DUT is idle.
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res,
                       input logic exp_ill, input string tag);
    exp_t e;
    int lat;
    chk({tag, "_hold"}, result_E, last_res);
    lat = (op[2] && !DIV_EN) ? 1 : (w ? 33 : 65);
    MdOp = op; w_arith = w; readData1_E = a; readData2_E = b; start_E = 1'b1;
    e.res = exp_res; e.ill = exp_ill; e.t0 = cyc; e.lat = lat;
    sb_q.push_back(e);
    last_res = exp_res;
    #1 chk({tag, "_stall_start"}, 64'(stall_E), 64'd1);
    finish_op(lat, tag);
  endtask

  initial begin
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b;
    int t0;

    // Reset state, checked while the clock runs and reset is held low.
    #3;
    chk("rst_result", result_E, 64'd0);
    chk("rst_busy", 64'(busy_E), 64'd0);
    chk("rst_done", 64'(done_E), 64'd0);
    chk("rst_illegal", 64'(illegal_E), 64'd0);
    chk("rst_stall", 64'(stall_E), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mul_7_m3");
    issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, dv(64'hFFFF_FFFF_FFFF_FFFD), !DIV_EN, "div_m7_2");
    issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, dv(64'hFFFF_FFFF_FFFF_FFFF), !DIV_EN, "rem_m7_2");
    issue(3'd5, 1'b0, 64'h1234, 64'd0, dv(64'hFFFF_FFFF_FFFF_FFFF), !DIV_EN, "divu_by0");
    issue(3'd7, 1'b0, 64'h1234, 64'd0, dv(64'h1234), !DIV_EN, "remu_by0");
    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          dv(64'h8000_0000_0000_0000), !DIV_EN, "div_ovf");
    issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, !DIV_EN, "rem_ovf");
    issue(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "mulw");

    // Flush at cycle 10 of a long op, restart at cycle 12.
    MdOp = DIV_EN ? 3'd5 : 3'd3; w_arith = 1'b0;
    readData1_E = 64'h1234_5678_9ABC_DEF0; readData2_E = 64'h0000_0000_0001_0003;
    start_E = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_E = 1'b0;
    for (int k = 0; k < 40 && cyc < t0 + 10; k++) @(negedge clk);
    flush_E = 1'b1;
    @(negedge clk);
    flush_E = 1'b0;
    chk("flush_busy", 64'(busy_E), 64'd0);
    chk("flush_done", 64'(done_E), 64'd0);
    chk("flush_result", result_E, last_res);
    @(negedge clk);
    issue(3'd5, 1'b0, 64'd1000, 64'd7, dv(64'd142), !DIV_EN, "after_flush");

    // Reset in the middle of a multiply.
    MdOp = 3'd0; w_arith = 1'b0; readData1_E = 64'd99; readData2_E = 64'd5;
    start_E = 1'b1;
    @(negedge clk);
    start_E = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_E), 64'd0);
    chk("midrst_done", 64'(done_E), 64'd0);
    chk("midrst_result", result_E, 64'd0);
    chk("midrst_illegal", 64'(illegal_E), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    last_res = '0;
    repeat (3) @(negedge clk);
    chk("postrst_idle", 64'(busy_E), 64'd0);
    issue(3'd0, 1'b0, 64'd99, 64'd5, 64'd495, 1'b0, "after_rst");

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom);
      a  = rnd_operand();
      b  = rnd_operand();
      issue(op, w, a, b, (op[2] && !DIV_EN) ? 64'd0 : model(op, w, a, b),
            op[2] && !DIV_EN, "rand");
    end

    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $fatal(1, "watchdog");
  end

endmodule
